// File: rtl/pd_pkg.sv
// pd_pkg: shared types, sizes and byte-swap helper for the proof-of-work datapath
package pd_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY} pd_hl_state_t;
  localparam int PD_HEADER_WORDS = 20;
  localparam int PD_CHUNK1_WORDS = 16;
  localparam int PD_NONCE_W = 32;
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
endpackage

// File: rtl/pd_nonce_incr.sv
// pd_nonce_incr: increments a byte-swapped (little-endian) nonce word and flags wrap to zero
module pd_nonce_incr
  import pd_pkg::*;
(
  input  logic [PD_NONCE_W-1:0] nonce_in,
  output logic [PD_NONCE_W-1:0] nonce_out,
  output logic                  wrap
);
  logic [PD_NONCE_W-1:0] le;
  // swap to numeric order, add one, swap back
  always_comb begin
    le = bswap32(nonce_in);
    nonce_out = bswap32(le + 1'b1);
    wrap = le == '1;
  end
endmodule

// File: rtl/pd_header_loader.sv
// pd_header_loader: streams an 80-byte header into chunk registers and sweeps its nonce in place
module pd_header_loader
  import pd_pkg::*;
#(
  parameter int HEADER_WORDS = PD_HEADER_WORDS,
  parameter int CHUNK1_WORDS = PD_CHUNK1_WORDS
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       load_start,
  input  logic [31:0]                                word_in,
  input  logic                                       word_valid,
  output logic                                       word_ready,
  input  logic                                       nonce_inc,
  output logic [32*CHUNK1_WORDS-1:0]                 chunk_1,
  output logic [32*(HEADER_WORDS-CHUNK1_WORDS)-1:0]  chunk_2,
  output logic                                       header_valid,
  output logic [4:0]                                 words_loaded,
  output logic                                       nonce_wrap
);
  localparam int C2_WORDS = HEADER_WORDS - CHUNK1_WORDS;
  pd_hl_state_t state, state_n;
  logic [31:0] c1 [CHUNK1_WORDS];
  logic [31:0] c2 [C2_WORDS];
  logic        xfer, last, wrap_next;
  logic [31:0] nonce_next;
  assign word_ready   = state == LOAD;
  assign header_valid = state == READY;
  assign xfer         = word_ready && word_valid && !load_start;
  assign last         = words_loaded == 5'(HEADER_WORDS - 1);
  pd_nonce_incr u_nonce (
    .nonce_in  (c2[C2_WORDS-1]),
    .nonce_out (nonce_next),
    .wrap      (wrap_next)
  );
  // next state: restart wins, last transfer completes the header
  always_comb state_n = load_start ? LOAD : (xfer && last) ? READY : state;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // chunk words, word counter and wrap pulse
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      c1           <= '{default: '0};
      c2           <= '{default: '0};
      words_loaded <= '0;
      nonce_wrap   <= 1'b0;
    end else begin
      nonce_wrap <= 1'b0;
      if (xfer) begin
        for (int i = 0; i < CHUNK1_WORDS; i++)
          if (words_loaded == 5'(i)) c1[i] <= word_in;
        for (int i = 0; i < C2_WORDS; i++)
          if (words_loaded == 5'(CHUNK1_WORDS + i)) c2[i] <= word_in;
        words_loaded <= words_loaded + 5'd1;
      end else if (header_valid && nonce_inc) begin
        c2[C2_WORDS-1] <= nonce_next;
        nonce_wrap     <= wrap_next;
      end
    end
  end
  for (genvar i = 0; i < CHUNK1_WORDS; i++) begin : g_c1
    assign chunk_1[32*(CHUNK1_WORDS-i)-1 -: 32] = c1[i];
  end
  for (genvar i = 0; i < C2_WORDS; i++) begin : g_c2
    assign chunk_2[32*(C2_WORDS-i)-1 -: 32] = c2[i];
  end
endmodule

// File: tb/tb_pd_header_loader.sv
// tb_pd_header_loader: randomized load/nonce stimulus checked against a header-level reference model
module tb_pd_header_loader;
  logic         tb_clk = 1'b0, rst = 1'b1, load_start = 1'b0, word_valid = 1'b0, nonce_inc = 1'b0;
  logic [31:0]  word_in = '0;
  logic         word_ready, header_valid, nonce_wrap;
  logic [511:0] chunk_1;
  logic [127:0] chunk_2;
  logic [4:0]   words_loaded;
  int           total = 0, bad = 0;
  logic [31:0]  src [20];
  logic [31:0]  hdr [20];
  int           n_exp = 0, mode_exp = 0;
  logic         wrap_exp = 1'b0;

  pd_header_loader dut (
    .clk          (tb_clk),
    .rst          (rst),
    .load_start   (load_start),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .nonce_inc    (nonce_inc),
    .chunk_1      (chunk_1),
    .chunk_2      (chunk_2),
    .header_valid (header_valid),
    .words_loaded (words_loaded),
    .nonce_wrap   (nonce_wrap)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [511:0] c1_of(input int n);
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r = (r << 32) | (i < n ? 512'(hdr[i]) : 512'd0);
    return r;
  endfunction

  function automatic logic [127:0] c2_of(input int n);
    logic [127:0] r = '0;
    for (int i = 16; i < 20; i++) r = (r << 32) | (i < n ? 128'(hdr[i]) : 128'd0);
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".c1"}, chunk_1, c1_of(n_exp));
    chk({tag, ".c2"}, 512'(chunk_2), 512'(c2_of(n_exp)));
    chk({tag, ".wl"}, 512'(words_loaded), 512'(n_exp));
    chk({tag, ".hv"}, 512'(header_valid), 512'(mode_exp == 2));
    chk({tag, ".rdy"}, 512'(word_ready), 512'(mode_exp == 1));
    chk({tag, ".wrap"}, 512'(nonce_wrap), 512'(wrap_exp));
  endtask

  task automatic tick(input string tag);
    logic [31:0] le;
    wrap_exp = 1'b0;
    if (rst) begin
      mode_exp = 0;
      n_exp = 0;
    end else if (load_start) begin
      mode_exp = 1;
      n_exp = 0;
    end else if (mode_exp == 1 && word_valid) begin
      hdr[n_exp] = word_in;
      n_exp++;
      if (n_exp == 20) mode_exp = 2;
    end else if (mode_exp == 2 && nonce_inc) begin
      le = sw(hdr[19]);
      wrap_exp = le == 32'hFFFF_FFFF;
      hdr[19] = sw(le + 32'd1);
    end
    @(posedge tb_clk);
    #1;
    check_all(tag);
  endtask

  task automatic start(input string tag);
    load_start = 1'b1;
    word_valid = 1'($urandom % 2);
    word_in = $urandom;
    nonce_inc = 1'($urandom % 2);
    tick(tag);
    load_start = 1'b0;
  endtask

  task automatic feed(input int mode, input int k, input string tag);
    int guard = 0;
    while (n_exp < k && guard < 400) begin
      word_valid = mode == 0 ? 1'b1 : mode == 1 ? 1'(guard % 2) : 1'($urandom % 3 != 0);
      word_in = word_valid ? src[n_exp] : $urandom;
      nonce_inc = 1'($urandom % 2);
      tick(tag);
      guard++;
    end
    if (guard >= 400) begin
      bad++;
      $display("FAIL budget %s loaded=%0d need=%0d", tag, n_exp, k);
    end
    word_valid = 1'b0;
    nonce_inc = 1'b0;
  endtask

  task automatic pulse_inc(input string tag);
    nonce_inc = 1'b1;
    tick(tag);
    nonce_inc = 1'b0;
  endtask

  task automatic rand_src;
    for (int i = 0; i < 20; i++) src[i] = $urandom;
  endtask

  initial begin
    for (int i = 0; i < 20; i++) hdr[i] = '0;
    rst = 1'b1;
    tick("rst0");
    tick("rst1");
    rst = 1'b0;
    word_valid = 1'b1;
    word_in = 32'hDEAD_BEEF;
    nonce_inc = 1'b1;
    repeat (3) tick("idle");
    word_valid = 1'b0;
    nonce_inc = 1'b0;

    rand_src();
    src[0] = 32'h0100_0000;
    src[16] = 32'h4247_e9f3;
    src[17] = 32'h3722_1b4d;
    src[18] = 32'h4c86_041b;
    src[19] = 32'h0f2b_5710;
    start("full_st");
    feed(0, 20, "full");
    chk("full_c2_const", 512'(chunk_2), 512'(128'h4247e9f337221b4d4c86041b0f2b5710));
    word_valid = 1'b1;
    repeat (2) tick("rdy_ignore");
    word_valid = 1'b0;
    pulse_inc("inc1");
    chk("inc1_const", 512'(chunk_2), 512'(128'h4247e9f337221b4d4c86041b102b5710));

    src[19] = 32'hFF00_0000;
    start("stall_st");
    feed(1, 20, "stall");
    pulse_inc("carry");
    chk("carry_const", 512'(chunk_2[31:0]), 512'(32'h0001_0000));

    src[19] = 32'hFFFF_FFFF;
    start("wrap_st");
    feed(0, 20, "wrapld");
    pulse_inc("wrap");
    chk("wrap_const", 512'({chunk_2[31:0], nonce_wrap}), 512'({32'h0, 1'b1}));
    tick("wrap_after");

    rand_src();
    start("rs_st");
    feed(0, 10, "rs_part");
    load_start = 1'b1;
    word_valid = 1'b1;
    word_in = src[10];
    tick("restart");
    load_start = 1'b0;
    feed(2, 20, "rs_full");

    rand_src();
    start("rst7_st");
    feed(0, 7, "rst7_part");
    rst = 1'b1;
    word_valid = 1'b1;
    word_in = src[7];
    tick("rst7");
    rst = 1'b0;
    word_valid = 1'b0;
    tick("rst7_idle");

    rand_src();
    start("ln_st");
    feed(2, 20, "ln_full");
    load_start = 1'b1;
    nonce_inc = 1'b1;
    tick("ln_both");
    load_start = 1'b0;
    nonce_inc = 1'b0;
    feed(0, 20, "ln_reload");
    chk("ln_nonce", 512'(chunk_2[31:0]), 512'(src[19]));

    repeat (6) begin
      rand_src();
      if ($urandom % 2 == 1) src[19] = sw(32'hFFFF_FFFF - $urandom_range(0, 4));
      start("rnd_st");
      feed(2, 20, "rnd_ld");
      repeat (12) begin
        nonce_inc = 1'($urandom % 4 != 0);
        word_valid = 1'($urandom % 2);
        tick("rnd_inc");
      end
      nonce_inc = 1'b0;
      word_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pd_header_loader.md
# pd_header_loader

Upstream stage of the chunk decoder in the proof-of-work datapath. It receives an 80-byte block header as 20 32-bit words over a valid/ready stream and assembles it into a 512-bit `chunk_1` and a 128-bit `chunk_2`. It holds both chunks stable for the decoder and hashing cores. On request it increments the little-endian nonce in place, so the miner can sweep nonces without reloading the header.

## Interface
Parameters:
- `HEADER_WORDS`, 20: header length in 32-bit words.
- `CHUNK1_WORDS`, 16: words routed to `chunk_1`; the remainder go to `chunk_2`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_start`  in  1  single-cycle pulse; starts a new header load.
- `word_in`  in  32  header word, first header byte in bits [31:24].
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `nonce_inc`  in  1  single-cycle pulse; increment the nonce.
- `chunk_1`  out  512  header bytes 0–63; byte 0 in [511:504].
- `chunk_2`  out  128  header bytes 64–79; nonce bytes 76–79 in [31:0].
- `header_valid`  out  1  full header loaded, chunks stable.
- `words_loaded`  out  5  number of words accepted in the current load.
- `nonce_wrap`  out  1  one-cycle pulse when the nonce wraps to zero.

## Operation
States are IDLE, LOAD and READY. Reset enters IDLE.

- IDLE: `word_ready`=0. `load_start` clears `chunk_1`, `chunk_2` and `words_loaded`, then moves to LOAD.
- LOAD: `word_ready`=1.
  - Each transfer (`word_valid` & `word_ready` at the edge) writes `word_in` to the slot for word index k = `words_loaded`, then increments `words_loaded`.
  - For k<16, the slot is `chunk_1[511-32k -: 32]`.
  - For k≥16, the slot is `chunk_2[127-32(k-16) -: 32]`.
  - The transfer of the 20th word (k=19) moves to READY.
- READY: `header_valid`=1, `word_ready`=0, `words_loaded`=20.
  - `nonce_inc` updates the nonce: `chunk_2[31:0]` ← bswap(bswap(`chunk_2[31:0]`)+1), mod 2^32.
  - If the pre-increment little-endian value is 0xFFFFFFFF, the result is 0 and `nonce_wrap` pulses.
- `load_start` in any non-IDLE state restarts the load: clear, then LOAD.
- Priority order: `rst` > `load_start` > word transfer / `nonce_inc`.
- `nonce_inc` outside READY is ignored.
- `word_valid` outside LOAD is ignored; no word is consumed.

## Timing
Reset values: `chunk_1`=0, `chunk_2`=0, `words_loaded`=0, `header_valid`=0, `nonce_wrap`=0, `word_ready`=0.

- `word_ready` and `header_valid` are decoded from registered state only, with no combinational path from inputs.
- The first word can be accepted in the cycle after the `load_start` edge.
- Maximum throughput is one word per cycle. Minimum load is 21 cycles from `load_start` to `header_valid` high.
- `header_valid` rises in the cycle after the 20th transfer edge.
- `header_valid` drops in the cycle after a `load_start` edge.
- A nonce update is visible on `chunk_2` one cycle after the `nonce_inc` edge. Back-to-back pulses give one increment per cycle.
- `nonce_wrap` is registered and coincides with the wrapped `chunk_2` value.
- `rst` asserted mid-load forces IDLE with all outputs at reset values on the next edge. Partial data is discarded.
- `load_start` and `word_valid` in the same cycle: the word is not consumed, and the upstream source must hold it.

## Structure
- Shared package `pd_pkg` holds:
  - the state enum `pd_hl_state_t` (IDLE, LOAD, READY);
  - constants `PD_HEADER_WORDS`=20, `PD_CHUNK1_WORDS`=16, `PD_NONCE_W`=32;
  - a `bswap32` function, shared with the chunk decoder's endian flip.
- One sub-module, `pd_nonce_incr`: combinational 32-bit byte-swap, increment and byte-swap back, with a wrap flag output.
- The chunk registers, counter and FSM live in the top module.

## Test plan
1. Reset then idle: assert `rst` for 2 cycles → all outputs 0. Drive `word_valid`=1 with no `load_start` → `words_loaded` stays 0 and `word_ready` stays 0.
2. Full load: `load_start`, then stream 20 words back-to-back (no stalls) → `chunk_1`=512'h01000000501201…efb5a4ac, `chunk_2`=128'h4247e9f337221b4d4c86041b0f2b5710. `header_valid` rises exactly 21 cycles after `load_start`.
3. Stalled load: deassert `word_valid` on alternate cycles → same chunk values. `words_loaded` increments only on transfer cycles.
4. Nonce increment:
   - From test 2, one `nonce_inc` → `chunk_2[31:0]`=32'h102b5710, rest unchanged.
   - Starting from 32'hFF000000 → 32'h00010000 (carry across bytes).
5. Nonce wrap: `chunk_2[31:0]`=32'hFFFFFFFF, `nonce_inc` → 32'h00000000 with a single-cycle `nonce_wrap`.
6. Restart and reset mid-load:
   - `load_start` after 10 words → chunks cleared, `words_loaded`=0. A fresh 20-word load completes correctly.
   - Separately, `rst` at word 7 → IDLE with reset values.
   - `load_start` and `nonce_inc` in the same cycle → restart, nonce unchanged.
